// File: rtl/mero_bus_pkg.sv
// Shared types and constants for the CPU memory-bus arbiter.
package mero_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [3:0]  BE_ALL    = 4'b1111;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts wait cycles of one bus phase; expired is high once the count reaches TIMEOUT.
// Latency: combinational expired from the count register; TIMEOUT=0 never expires.
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises each CPU step onto one memory bus: optional data phase, optional fetch phase, then a
// one-cycle cpu_ready_o pulse. Stalls in a phase while bus_ready_i is low, bounded by TIMEOUT.
module mem_bus_arbiter
  import mero_bus_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_rd_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic [DATA_W-1:0] instr_data_o,
  input  logic              data_rd_i,
  input  logic              data_wr_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  input  logic [3:0]        data_be_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              cpu_ready_o,
  output logic              bus_valid_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [3:0]        bus_be_o,
  input  logic              bus_ready_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              timeout_o
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] instr_q, rdata_q;
  logic              timeout_q;
  logic              in_phase, expired, abort, phase_end;

  assign in_phase  = (state == DATA) || (state == INSTR);
  // A ready in the expiry cycle counts as a normal accept, not a timeout.
  assign abort     = in_phase && expired && !bus_ready_i;
  assign phase_end = in_phase && (bus_ready_i || expired);

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear    (!in_phase || phase_end),
    .count_en (in_phase && !bus_ready_i),
    .expired  (expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cpu_ready_o = 1'b0;
    bus_valid_o = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    bus_be_o    = '0;
    case (state)
      IDLE: begin
        if (data_rd_i || data_wr_i) state_nxt = DATA;
        else if (instr_rd_i)        state_nxt = INSTR;
        else                        state_nxt = DONE;
      end
      DATA: begin
        bus_valid_o = 1'b1;
        bus_we_o    = data_wr_i;
        bus_addr_o  = data_addr_i;
        bus_wdata_o = data_wr_i ? data_wdata_i : '0;
        bus_be_o    = data_wr_i ? data_be_i : BE_ALL;
        if (phase_end) state_nxt = instr_rd_i ? INSTR : DONE;
      end
      INSTR: begin
        bus_valid_o = 1'b1;
        bus_addr_o  = instr_addr_i;
        bus_be_o    = BE_ALL;
        if (phase_end) state_nxt = DONE;
      end
      DONE: begin
        cpu_ready_o = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured words hold steady through DONE so the pipeline sees them as it advances.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q   <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == DATA && !data_wr_i) begin
        if (bus_ready_i)  rdata_q <= bus_rdata_i;
        else if (expired) rdata_q <= '0;
      end
      if (state == INSTR) begin
        if (bus_ready_i)  instr_q <= bus_rdata_i;
        else if (expired) instr_q <= DATA_W'(NOP_INSTR);
      end
      if (abort) timeout_q <= 1'b1;
    end
  end

  assign instr_data_o = instr_q;
  assign data_rdata_o = rdata_q;
  assign timeout_o    = timeout_q;

endmodule
